// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port CPU memory between instruction fetch (If) and
//   load/store (D). One access at a time, fixed read latency MEM_LAT
//   (1..15). Ties are broken round-robin against Owner.
//
// Ports
//   clk, Reset               clock, synchronous active-low reset
//   IfReq/IfAddr             fetch request (level) and address
//   IfRdata/IfDone           fetched word (registered), one-cycle done pulse
//   DReq/DWe/DAddr/DWdata    data request (level), write flag, address, store data
//   DRdata/DDone             load data (registered), one-cycle done pulse
//   MemAddr/MemWdata         memory address / write data, held for the access
//   MemWrite                 write strobe, first ACCESS cycle of a write only
//   MemRdata                 memory read data
//   MemReady                 only with ARB_MEM_WAIT_EN: extends the access
//   Busy                     high in ACCESS and DONE
//   Owner                    current/last grantee, 0 = If, 1 = D
//
// Optional feature macro: ARB_MEM_WAIT_EN (adds MemReady wait states).

module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [DATA_W-1:0] IfRdata,
  output logic              IfDone,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DDone,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRdata,
`ifdef ARB_MEM_WAIT_EN
  input  logic              MemReady,
`endif
  output logic              Busy,
  output logic              Owner
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accWe;     // write flag of the access in flight
  logic             grantD;
  logic             atLast;
  logic             finish;

  // Both requesting: hand the memory to the port that did not own it last.
  assign grantD = DReq & (~IfReq | ~Owner);
  assign atLast = (cnt == LAST);

`ifdef ARB_MEM_WAIT_EN
  assign finish = atLast & MemReady;
`else
  assign finish = atLast;
`endif

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      accWe    <= 1'b0;
      IfRdata  <= '0;
      DRdata   <= '0;
      MemAddr  <= '0;
      MemWdata <= '0;
      MemWrite <= 1'b0;
      IfDone   <= 1'b0;
      DDone    <= 1'b0;
      Busy     <= 1'b0;
      Owner    <= 1'b1;
    end else begin
      IfDone   <= 1'b0;
      DDone    <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (IfReq | DReq) begin
            Owner    <= grantD;
            MemAddr  <= grantD ? DAddr : IfAddr;
            // Fetches never write; drive a clean zero on the write bus.
            MemWdata <= grantD ? DWdata : '0;
            accWe    <= grantD & DWe;
            MemWrite <= grantD & DWe;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (finish) begin
            if (!accWe) begin
              if (Owner) DRdata  <= MemRdata;
              else       IfRdata <= MemRdata;
            end
            if (Owner) DDone  <= 1'b1;
            else       IfDone <= 1'b1;
            state <= DONE;
          end else if (!atLast) begin
            // Saturates at LAST while waiting for MemReady.
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
